// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: mem_op codes,
// RV32I load/store funct3 encodings, access sizes, FSM state type and
// small helpers for alignment and byte-enable generation.
package mem_stage_pkg;

  // mem_op_i codes; any code with bit 1 set is a store
  localparam logic [1:0] MEM_OP_NONE = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD = 2'b01;

  // RV32I load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } access_size_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  // Access size from funct3; the unused encodings with bit 1 set act as words
  function automatic access_size_t size_of(input logic [2:0] funct3);
    access_size_t size;
    case (funct3[1:0])
      2'b00:   size = SIZE_BYTE;
      2'b01:   size = SIZE_HALF;
      default: size = SIZE_WORD;
    endcase
    return size;
  endfunction

  // True when the low address bits are not a multiple of the access size
  function automatic logic is_misaligned(input access_size_t size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte offset inside the word after clearing bits that break alignment
  function automatic logic [1:0] align_offset(input access_size_t size, input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SIZE_BYTE: off = addr_lo;
      SIZE_HALF: off = {addr_lo[1], 1'b0};
      default:   off = 2'b00;
    endcase
    return off;
  endfunction

  // Byte-lane enables for an aligned access at the given offset
  function automatic logic [3:0] byte_enable(input access_size_t size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << {off[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3. Purely combinational.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane and extend it to the full data width
  always_comb begin
    byte_s = rdata[{offset, 3'b000} +: 8];
    half_s = rdata[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
      F3_LH:   data = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_s};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Non-memory ops retire one cycle after
// acceptance; loads and stores issue a single bus request and retire on the
// bus acknowledge. A flush during an access lets the bus transfer finish but
// suppresses its retirement.
// Build option: MEM_MISALIGN_TRAP_EN -- misaligned half/word accesses are
// rejected with a one-cycle misalign_o pulse instead of being force-aligned.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [1:0]            mem_op_i,
  input  logic [2:0]            funct3_i,
  input  logic [4:0]            rd_i,
  input  logic                  reg_write_i,
  input  logic                  flush_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [DATA_WIDTH-1:0] bus_addr_o,
  output logic [3:0]            bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic                  wb_reg_write_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  misalign_o
);

  mem_state_t            state_r;
  mem_state_t            state_nx_s;

  logic                  accept_s;
  logic                  is_mem_s;
  logic                  is_store_s;
  logic                  trap_s;
  logic                  start_s;
  logic                  done_s;
  logic                  kill_s;
  access_size_t          size_s;
  logic [1:0]            off_s;
  logic [DATA_WIDTH-1:0] addr_word_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [3:0]            be_s;
  logic [DATA_WIDTH-1:0] load_data_s;

  // Context of the access in flight, needed when the ack arrives
  logic [4:0]            rd_r;
  logic                  reg_write_r;
  logic [2:0]            funct3_r;
  logic [1:0]            off_r;
  logic                  store_r;
  logic                  kill_r;
  logic [DATA_WIDTH-1:0] result_r;

  assign ex_ready_o  = (state_r == ST_IDLE);
  assign accept_s    = ex_valid_i & ex_ready_o & ~flush_i;
  assign is_mem_s    = (mem_op_i != MEM_OP_NONE);
  assign is_store_s  = mem_op_i[1];
  assign size_s      = size_of(funct3_i);
  assign off_s       = align_offset(size_s, alu_result_i[1:0]);
  assign be_s        = byte_enable(size_s, off_s);
  assign addr_word_s = {alu_result_i[DATA_WIDTH-1:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_s = accept_s & is_mem_s & is_misaligned(size_s, alu_result_i[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  assign start_s = accept_s & is_mem_s & ~trap_s;
  assign done_s  = (state_r == ST_ACCESS) & bus_req_o & bus_ack_i;
  // A flush seen at any point of the access, including the ack cycle, kills it
  assign kill_s  = kill_r | flush_i;

  // Replicate store data across all byte lanes of the bus
  always_comb begin
    case (size_s)
      SIZE_BYTE: wdata_s = {(DATA_WIDTH/8){store_data_i[7:0]}};
      SIZE_HALF: wdata_s = {(DATA_WIDTH/16){store_data_i[15:0]}};
      default:   wdata_s = store_data_i;
    endcase
  end

  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .rdata  (bus_rdata_i),
    .offset (off_r),
    .funct3 (funct3_r),
    .data   (load_data_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state: leave IDLE on a memory op, return on the bus ack
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nx_s = ST_ACCESS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (done_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ACCESS;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Bus request register: launched on a memory op, held until the ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= {DATA_WIDTH{1'b0}};
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= {DATA_WIDTH{1'b0}};
    end else if (start_s) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= is_store_s;
      bus_addr_o  <= addr_word_s;
      bus_be_o    <= be_s;
      bus_wdata_o <= wdata_s;
    end else if (done_s) begin
      bus_req_o   <= 1'b0;
    end
  end

  // Capture the in-flight instruction's context and track a pending flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_r        <= 5'd0;
      reg_write_r <= 1'b0;
      funct3_r    <= 3'b000;
      off_r       <= 2'b00;
      store_r     <= 1'b0;
      kill_r      <= 1'b0;
      result_r    <= {DATA_WIDTH{1'b0}};
    end else if (start_s) begin
      rd_r        <= rd_i;
      reg_write_r <= reg_write_i & ~is_store_s;
      funct3_r    <= funct3_i;
      off_r       <= off_s;
      store_r     <= is_store_s;
      kill_r      <= 1'b0;
      result_r    <= alu_result_i;
    end else if ((state_r == ST_ACCESS) && flush_i) begin
      kill_r      <= 1'b1;
    end
  end

  // MEM/WB register: one-cycle retire pulse for ALU ops and completed accesses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_o     <= 1'b0;
      wb_rd_o        <= 5'd0;
      wb_reg_write_o <= 1'b0;
      wb_data_o      <= {DATA_WIDTH{1'b0}};
    end else if (accept_s && !is_mem_s) begin
      wb_valid_o     <= 1'b1;
      wb_rd_o        <= rd_i;
      wb_reg_write_o <= reg_write_i;
      wb_data_o      <= alu_result_i;
    end else if (done_s && !kill_s) begin
      wb_valid_o     <= 1'b1;
      wb_rd_o        <= rd_r;
      wb_reg_write_o <= reg_write_r;
      wb_data_o      <= store_r ? result_r : load_data_s;
    end else begin
      wb_valid_o     <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned-access pulse, one cycle per rejected instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= trap_s;
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid_i  in  1  EX/MEM holds a valid instruction.
REQ-005 SHALL have port ex_ready_o  out  1  stage accepts an instruction this cycle.
REQ-006 SHALL have port alu_result_i  in  DATA_WIDTH  memory address, or result for non-memory ops.
REQ-007 SHALL have port store_data_i  in  DATA_WIDTH  rs2 value for stores.
REQ-008 SHALL have port mem_op_i  in  2  00 none, 01 load, 1x store.
REQ-009 SHALL have port funct3_i  in  3  access size and sign (RV32I load/store encoding).
REQ-010 SHALL have port rd_i  in  5  destination register.
REQ-011 SHALL have port reg_write_i  in  1  instruction writes rd.
REQ-012 SHALL have port flush_i  in  1  kill the current and incoming instruction.
REQ-013 SHALL have port bus_req_o  out  1  data-bus request.
REQ-014 SHALL have port bus_we_o  out  1  1 store, 0 load.
REQ-015 SHALL have port bus_addr_o  out  DATA_WIDTH  aligned word address.
REQ-016 SHALL have port bus_be_o  out  4  byte enables.
REQ-017 SHALL have port bus_wdata_o  out  DATA_WIDTH  lane-replicated store data.
REQ-018 SHALL have port bus_ack_i  in  1  bus completes the access this cycle.
REQ-019 SHALL have port bus_rdata_i  in  DATA_WIDTH  read word, valid with bus_ack_i.
REQ-020 SHALL have port wb_valid_o  out  1  MEM/WB holds a retired instruction.
REQ-021 SHALL have port wb_rd_o  out  5  registered rd.
REQ-022 SHALL have port wb_reg_write_o  out  1  registered write enable, forced 0 for stores.
REQ-023 SHALL have port wb_data_o  out  DATA_WIDTH  ALU result or extended load data.
REQ-024 SHALL have port misalign_o  out  1  one-cycle misaligned-access pulse.

Function
REQ-025 SHALL use FSM states IDLE and ACCESS; ex_ready_o = (state==IDLE); accept = ex_valid_i & ex_ready_o & ~flush_i.
REQ-026 SHALL, on accept with mem_op_i==00, register wb_* at that edge (1-cycle latency) with wb_valid_o=1, and stay in IDLE.
REQ-027 SHALL, on accept with a memory op, enter ACCESS at that edge with bus_req_o=1 and addr/be/wdata/we registered and held stable until the ack.
REQ-028 SHALL complete the access at the first edge where bus_req_o&bus_ack_i=1 (ack in the first ACCESS cycle allowed): register wb_*, deassert bus_req_o, and return to IDLE.
REQ-029 SHALL drive bus_be_o as: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111; store data SHALL be replicated across lanes.
REQ-030 SHALL select load data by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW and unused funct3 pass the full word.
REQ-031 SHALL pulse wb_valid_o for exactly one cycle per retired instruction; otherwise 0.
REQ-032 SHALL drop an incoming instruction when flush_i=1 coincides with ex_valid_i, with no wb_valid_o and no bus request.
REQ-033 SHALL NOT abort a bus access when flush_i is asserted in ACCESS; the access completes and wb_valid_o stays 0 for it.

Reset
REQ-034 SHALL, while reset=0, force state IDLE and all outputs 0 except ex_ready_o=1; reset in ACCESS abandons the access and drops bus_req_o immediately.

Configuration
REQ-035 SHALL, with MEM_MISALIGN_TRAP_EN defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 as misaligned: no bus request, misalign_o=1 for one cycle, no wb_valid_o, stay IDLE.
REQ-036 SHALL, without MEM_MISALIGN_TRAP_EN, clear the offending low address bits (access proceeds aligned) and tie misalign_o to 0.

Structure
REQ-037 SHALL keep the funct3 size encodings, mem_op_i codes and the FSM state type in shared package mem_stage_pkg.
REQ-038 SHALL implement load lane selection and extension in combinational sub-module load_align.

Verification
REQ-039 SHALL check: ALU op, alu_result_i=0x12345678, rd=5 -> next cycle wb_valid_o=1, wb_data_o=0x12345678, wb_rd_o=5.
REQ-040 SHALL check: LB at addr 0x103, ack after 3 cycles with rdata=0x80FFFFFF -> bus_be_o=1000, ex_ready_o low for 3 cycles, wb_data_o=0xFFFFFF80.
REQ-041 SHALL check: SH at 0x202, store_data=0xABCD -> bus_addr_o=0x200, bus_be_o=1100, bus_wdata_o=0xABCDABCD, wb_reg_write_o=0.
REQ-042 SHALL check: flush_i in second ACCESS cycle of an LW -> bus completes on ack, wb_valid_o stays 0, next op accepted.
REQ-043 SHALL check: LW at 0x6 -> with MEM_MISALIGN_TRAP_EN, misalign_o pulse and no bus_req_o; without it, bus_addr_o=0x4.
REQ-044 SHALL check: reset=0 asserted in ACCESS -> bus_req_o=0 immediately, ex_ready_o=1, wb_valid_o=0.
